tone_period_meter: RTL



---
 rtl/tone_period_meter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tone_period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of a clk-synchronous tone.
// Define TPM_SYNC_EN to add a two-flop synchronizer so f_in may be asynchronous.
module tone_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_in,
  input  logic             clr,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;
  logic             f_src;
  logic             f_q, f_qq;
  logic             rise, fall;

`ifdef TPM_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= f_in;
      sync2_q <= sync1_q;
    end
  end

  assign f_src = sync2_q;
`else
  assign f_src = f_in;
`endif

  // Edge-detect flops keep sampling through clr so no edge is fabricated afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_q  <= 1'b0;
      f_qq <= 1'b0;
    end else begin
      f_q  <= f_src;
      f_qq <= f_q;
    end
  end

  assign rise = f_q & ~f_qq;
  assign fall = ~f_q & f_qq;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      high_d   = '0;
      locked_d = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = WIDTH'(1);
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still counts as a measurement.
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            ovf_d    = 1'b0;
            cnt_d    = WIDTH'(1);
          end else if (cnt_q == CNT_MAX) begin
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
            if (fall) high_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign ovf       = ovf_q;

endmodule
